quad_step_decoder: RTL
======================

Name: quad_step_decoder

Overview:
- Front end for the team's up/down position counter: converts a two-channel quadrature encoder (A/B) into single-cycle step pulses plus a direction bit.
- step drives the counter's count-enable path; up drives its up/down select directly.
- Includes input synchronisation, per-channel glitch filtering, illegal-transition detection and a sticky error flag.

Parameters:
- FILT_CYCLES, 4, consecutive cycles a synchronised input must differ from its filtered value before the filtered value changes (legal range 1..15).
- FW, $clog2(FILT_CYCLES+1), width of each filter counter (derived; not overridden).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- a_in  input  1  raw encoder channel A (asynchronous)
- b_in  input  1  raw encoder channel B (asynchronous)
- en  input  1  1 = steps reported; 0 = steps suppressed, tracking continues
- err_clr  input  1  clears err
- step  output  1  one-cycle pulse per legal quadrature transition
- up  output  1  direction of the current or most recent step (1 = up)
- err  output  1  sticky illegal-transition flag
- phase  output  2  filtered {A,B}

Behaviour:
- Reset (reset=1 at a clk edge): sync flops, filtered values, filter counters, prev state and phase all go to 0. step=0, up=0, err=0, primed=0, init counter=0.
- Synchroniser: two flops per channel. sync2 is the only value the filter sees.
- Filter, per channel:
  - If sync2 != filt, the counter increments.
  - When the counter reaches FILT_CYCLES, filt takes sync2 and the counter clears on that same edge.
  - If sync2 == filt, the counter clears. A pulse shorter than FILT_CYCLES cycles never reaches filt.
- Priming:
  - After reset deasserts, a 2-bit init counter counts 3 edges, then primed=1.
  - While primed=0, filt loads sync2 directly every cycle and prev loads {filtA,filtB}. No step and no err are generated.
  - This prevents a false error when the encoder rests at 11 out of reset.
- Decode, when primed=1, compares cur={filtA,filtB} with prev every cycle, then sets prev<=cur:
  - Up sequence: 00->01->11->10->00. Gives step=1 (if en=1) and up=1.
  - Down sequence: the reverse. Gives step=1 (if en=1) and up=0.
  - cur==prev: step=0, up holds.
  - Both bits changed in the same cycle (00<->11, 01<->10): step=0, up holds, err<=1.
- Latency: a raw edge on a_in that is stable from before clk edge k produces step=1 in the cycle following edge k+2+FILT_CYCLES. That is 6 edges at the default setting. step stays high exactly one cycle.
- en=0: the step output is forced 0, but prev still updates, so re-asserting en never emits a stale step. up still updates on legal transitions; err still sets.
- err_clr=1: err<=0 on the next edge. An error detected in the same cycle as err_clr wins (err stays 1).
- phase = cur at all times (registered filt values).
- Reset mid-operation: all state returns to the reset values above and priming restarts. No step is emitted during or after reset until primed=1.

Decomposition:
- Package quad_pkg:
  - typedef logic [1:0] quad_phase_t
  - localparams for the four Gray phases (PH_00, PH_01, PH_11, PH_10)
  - INIT_CYCLES = 3
  - function quad_dir (prev, cur) returning {legal, up, changed}
- Sub-module quad_glitch_filter (parameter FILT_CYCLES; ports clk, reset, load, raw, filt): contains the two-flop synchroniser and the stable-count filter. The load input forces filt from sync2 during priming. Two instances, one per channel.
- The top level holds the init counter, prev register, decode, and step/up/err registers.

Test Plan:
- Prime: reset 2 cycles with a_in=b_in=1, release, wait 10 cycles -> phase=2'b11, err=0, no step ever asserted.
- Up sequence: from 00, apply 01,11,10,00, each held 10 cycles, en=1 -> exactly 4 step pulses, each one cycle wide, up=1. Each pulse appears 6 edges after its input change (FILT_CYCLES=4).
- Down plus enable: apply 10,11,01,00 with en=0 during the second transition -> 3 step pulses with up=0. No pulse when en rises again.
- Glitch: from 00, pulse a_in high for 3 cycles -> no step, phase stays 00. A 4-cycle-stable high -> one step, up=1.
- Illegal transition: from 00, switch both inputs to 11 in the same cycle and hold -> step stays 0, err=1. err_clr for 1 cycle -> err=0. Repeat with err_clr asserted in the detect cycle -> err=1.
- Mid-operation reset: assert reset in the middle of an up sequence -> step=0, up=0, err=0, phase=00 on the next edge. After release, steps resume correctly only after priming.

Source files
------------

// File: rtl/quad_pkg.sv
// Shared types and decode helper for the quadrature step decoder.
// Phases are {A,B}; the up direction walks 00 -> 01 -> 11 -> 10 -> 00.
package quad_pkg;

  typedef logic [1:0] quad_phase_t;

  localparam quad_phase_t PH_00 = 2'b00;
  localparam quad_phase_t PH_01 = 2'b01;
  localparam quad_phase_t PH_11 = 2'b11;
  localparam quad_phase_t PH_10 = 2'b10;

  localparam int INIT_CYCLES = 3;

  typedef struct packed {
    logic legal;    // exactly one channel changed
    logic up;       // legal step in the up direction
    logic changed;  // any change at all
  } quad_dir_t;

  function automatic quad_dir_t quad_dir(input quad_phase_t prev, input quad_phase_t cur);
    quad_phase_t next_up;
    quad_dir_t   r;
    case (prev)
      PH_00:   next_up = PH_01;
      PH_01:   next_up = PH_11;
      PH_11:   next_up = PH_10;
      default: next_up = PH_00;
    endcase
    r.changed = (prev != cur);
    r.legal   = r.changed && ((prev ^ cur) != 2'b11);
    r.up      = r.legal && (cur == next_up);
    return r;
  endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// One encoder channel: two-flop synchroniser followed by a stable-count filter.
// load (used while priming) copies the synchronised value straight into filt.
module quad_glitch_filter #(
  parameter  int FILT_CYCLES = 4,
  localparam int FW          = $clog2(FILT_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic raw,
  output logic filt
);

  logic          sync1_q, sync2_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  // The edge that would bring the count to FILT_CYCLES is the one that
  // commits the new value, so a change needs FILT_CYCLES stable cycles.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (load) begin
      filt_d = sync2_q;
    end else if (sync2_q != filt_q) begin
      if (cnt_q == FW'(FILT_CYCLES - 1)) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign filt = filt_q;

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature A/B front end: filtered phase, one-cycle step pulses, direction
// and a sticky illegal-transition flag for the up/down position counter.
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int FILT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_in,
  input  logic        b_in,
  input  logic        en,
  input  logic        err_clr,
  output logic        step,
  output logic        up,
  output logic        err,
  output logic [1:0]  phase
);

  // Handshake: step is a valid-only strobe with no ready; the consumer must
  // accept it in the single cycle it is high, with up qualifying its direction.

  logic        filt_a, filt_b;
  logic        load;
  quad_phase_t cur;
  quad_dir_t   dir;

  logic [1:0]  init_cnt_q, init_cnt_d;
  logic        primed_q, primed_d;
  quad_phase_t prev_q, prev_d;
  logic        step_q, step_d;
  logic        up_q, up_d;
  logic        err_q, err_d;

  assign load = !primed_q;

  quad_glitch_filter #(.FILT_CYCLES(FILT_CYCLES)) u_filt_a (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .raw   (a_in),
    .filt  (filt_a)
  );

  quad_glitch_filter #(.FILT_CYCLES(FILT_CYCLES)) u_filt_b (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .raw   (b_in),
    .filt  (filt_b)
  );

  assign cur = {filt_a, filt_b};
  assign dir = quad_dir(prev_q, cur);

  always_ff @(posedge clk) begin
    if (reset) begin
      init_cnt_q <= '0;
      primed_q   <= 1'b0;
      prev_q     <= PH_00;
      step_q     <= 1'b0;
      up_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      init_cnt_q <= init_cnt_d;
      primed_q   <= primed_d;
      prev_q     <= prev_d;
      step_q     <= step_d;
      up_q       <= up_d;
      err_q      <= err_d;
    end
  end

  // primed is registered one edge after the count saturates so that prev has
  // caught up with the freshly loaded filter values before decoding starts.
  always_comb begin
    init_cnt_d = init_cnt_q;
    primed_d   = (init_cnt_q == 2'(INIT_CYCLES));
    prev_d     = cur;
    step_d     = 1'b0;
    up_d       = up_q;
    err_d      = err_q;

    if (init_cnt_q != 2'(INIT_CYCLES)) begin
      init_cnt_d = init_cnt_q + 2'd1;
    end

    if (primed_q && dir.legal) begin
      step_d = en;
      up_d   = dir.up;
    end

    if (primed_q && dir.changed && !dir.legal) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  assign step  = step_q;
  assign up    = up_q;
  assign err   = err_q;
  assign phase = cur;

endmodule
